// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 state type, default timing constants and parity helper
package ps2_pkg;

  // Default timing at 50 MHz: 100 us clock inhibit, 2 ms inter-edge timeout
  localparam int INHIBIT_CYCLES_DEF = 5000;
  localparam int TIMEOUT_CYCLES_DEF = 100000;

  // Wide enough for start + 8 data + parity + stop + ack bit positions
  localparam int BIT_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    DATA,
    PARITY,
    STOP,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  // PS/2 frames use odd parity over the eight data bits
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// rtl/ps2_sync.sv - two-flop synchronizer with falling-edge flag for one PS/2 line
module ps2_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain plus history flop; idle PS/2 lines float high so reset to 1
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_out = sync_q;
  // High for exactly one cycle after the synchronized line goes 1 -> 0
  assign fall     = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic clk_sync;
  logic clk_fall;
  logic data_sync;
  logic data_fall;
  logic unused_data_fall;

  ps2_state_t           state_q,   state_d;
  logic [INH_W-1:0]     inh_cnt_q, inh_cnt_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q,   shift_d;
  logic                 parity_q,  parity_d;
  logic                 ack_bit_q, ack_bit_d;
  logic                 clk_oe_q,  clk_oe_d;
  logic                 data_oe_q, data_oe_d;
  logic                 done_q,    done_d;
  logic                 ack_err_q, ack_err_d;
  logic                 timed;

  ps2_sync u_clk_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (ps2_clk_in),
    .sync_out (clk_sync),
    .fall     (clk_fall)
  );

  ps2_sync u_data_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (ps2_data_in),
    .sync_out (data_sync),
    .fall     (data_fall)
  );

  // Only the device clock edges pace the transmitter
  assign unused_data_fall = data_fall;

  // Next-state, counter and line-drive decisions; all outputs are registered below
  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    ack_bit_d = ack_bit_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    ack_err_d = 1'b0;

    // Watchdog runs only while the device owns the clock; INHIBIT holds it at 0,
    // so it starts cleared on entry to START
    timed = (state_q != IDLE) && (state_q != INHIBIT);
    if (timed) begin
      tmo_cnt_d = clk_fall ? '0 : tmo_cnt_q + TMO_W'(1);
    end else begin
      tmo_cnt_d = '0;
    end

    case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        inh_cnt_d = '0;
        bit_cnt_d = '0;
        // The cycle carrying done is already IDLE; a request there is dropped
        if (tx_start && !done_q) begin
          shift_d  = tx_data;
          parity_d = odd_parity(tx_data);
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          inh_cnt_d = '0;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = START;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
        end
      end
      START: begin
        // Device has clocked the start bit; put bit 0 on the line
        if (clk_fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = BIT_CNT_W'(1);
          state_d   = DATA;
        end
      end
      DATA: begin
        if (clk_fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(7)) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (clk_fall) begin
          data_oe_d = ~parity_q;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (clk_fall) begin
          data_oe_d = 1'b0;
          state_d   = ACK;
        end
      end
      ACK: begin
        if (clk_fall) begin
          ack_bit_d = data_sync;
          state_d   = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          done_d    = 1'b1;
          ack_err_d = ack_bit_q;
          state_d   = IDLE;
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    // A stalled device aborts the transfer and frees both lines
    if (timed && !clk_fall && (tmo_cnt_q == TMO_LAST)) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      done_d    = 1'b1;
      ack_err_d = 1'b1;
      tmo_cnt_d = '0;
      state_d   = IDLE;
    end
  end

  // State, datapath and registered line drivers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      inh_cnt_q <= '0;
      tmo_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      ack_bit_q <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_cnt_q <= inh_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      ack_bit_q <= ack_bit_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign ack_err     = ack_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

  localparam int INH  = 300;
  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       ack_err;

  always #5 clk = ~clk;

  // Open-collector bus: either side can pull a line low
  assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .ack_err     (ack_err)
  );

  int tests = 0;
  int failures = 0;
  int cyc = 0;

  logic [10:0] got_frame;
  int          got_inhibit;
  bit          busy_after_start;
  bit          busy_dropped;
  int          done_cnt;
  logic        got_ack_err;
  logic [1:0]  oe_at_done;
  int          done_cyc;
  int          last_fall_cyc;
  bit          bound_hit;
  int          overlap_cnt;
  bit          hold_start;
  bit          drop_pending;
  logic        post_done_busy;

  always @(posedge clk) cyc++;

  always @(negedge clk) if (ps2_clk_oe && ps2_data_oe) overlap_cnt++;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got %0d cycles, required under 90000", cyc);
    $fatal(1);
  end

  // Reference frame as the device sees it: start 0, data LSB first, odd parity, stop 1
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    int ones;
    logic [10:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    f[0]   = 1'b0;
    f[8:1] = d;
    f[9]   = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    f[10]  = 1'b1;
    return f;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (drop_pending) begin
      tx_start       = 1'b0;
      drop_pending   = 1'b0;
      post_done_busy = busy | ps2_clk_oe;
    end
    if (done) begin
      done_cnt++;
      got_ack_err = ack_err;
      oe_at_done  = {ps2_clk_oe, ps2_data_oe};
      done_cyc    = cyc;
      if (hold_start) begin
        drop_pending = 1'b1;
        hold_start   = 1'b0;
      end
    end else if (done_cnt == 0 && !busy) begin
      busy_dropped = 1'b1;
    end
  endtask

  // One device clock pulse; the host line is read just before the rising edge
  task automatic dev_edge(output logic smp);
    dev_clk       = 1'b0;
    last_fall_cyc = cyc;
    repeat (HALF) tick();
    smp     = ps2_data_in;
    dev_clk = 1'b1;
    repeat (HALF) tick();
  endtask

  task automatic do_xfer(input logic [7:0] d, input logic ack_good, input int n_edges,
                         input bit inject, input bit start_at_end);
    logic s;
    int   w;
    got_frame = '0; got_inhibit = 0; busy_dropped = 0; done_cnt = 0; got_ack_err = 1'b0;
    oe_at_done = 2'b11; bound_hit = 0; overlap_cnt = 0; post_done_busy = 1'b0;
    drop_pending = 0; hold_start = 0; busy_after_start = 0;
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    busy_after_start = busy;
    w = 0;
    while (ps2_clk_oe && w < INH + 50) begin
      w++;
      tick();
    end
    got_inhibit = w;
    if (w >= INH + 50) bound_hit = 1;
    got_frame[0] = ps2_data_in;
    repeat (4) tick();
    for (int k = 1; k <= n_edges; k++) begin
      if (inject && k == 3) begin
        tx_data  = 8'h00;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
      end
      if (k == 11) begin
        dev_data = ack_good ? 1'b0 : 1'b1;
        repeat (2) tick();
      end
      dev_edge(s);
      if (k <= 10) got_frame[k] = s;
    end
    if (n_edges == 11) begin
      dev_data = 1'b1;
      if (start_at_end) begin
        tx_data    = 8'h55;
        tx_start   = 1'b1;
        hold_start = 1'b1;
      end
    end
    w = 0;
    while (done_cnt == 0 && w < TMO + 100) begin
      w++;
      tick();
    end
    if (done_cnt == 0) bound_hit = 1;
    repeat (5) tick();
    tx_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (ps2_clk_oe !== 1'b0) begin failures++; $display("FAIL reset_clk_oe: got %b, required 0", ps2_clk_oe); end
    tests++; if (ps2_data_oe !== 1'b0) begin failures++; $display("FAIL reset_data_oe: got %b, required 0", ps2_data_oe); end
    tests++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", busy); end
    tests++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b, required 0", done); end
    tests++; if (ack_err !== 1'b0) begin failures++; $display("FAIL reset_ack_err: got %b, required 0", ack_err); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    tests++; if (busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin failures++; $display("FAIL idle_after_reset: got busy %b clk_oe %b, required 0 0", busy, ps2_clk_oe); end
  endtask

  task automatic test_send_ed();
    logic [10:0] e;
    e = exp_frame(8'hED);
    do_xfer(8'hED, 1'b1, 11, 0, 0);
    tests++; if (got_frame !== e) begin failures++; $display("FAIL ed_frame: got %b, required %b", got_frame, e); end
    tests++; if (done_cnt !== 1) begin failures++; $display("FAIL ed_done_count: got %0d, required 1", done_cnt); end
    tests++; if (got_ack_err !== 1'b0) begin failures++; $display("FAIL ed_ack_err: got %b, required 0", got_ack_err); end
    tests++; if (bound_hit !== 1'b0) begin failures++; $display("FAIL ed_bound: got %b, required 0", bound_hit); end
    tests++; if (!(overlap_cnt <= 1)) begin failures++; $display("FAIL ed_oe_overlap: got %0d cycles, required at most 1", overlap_cnt); end
  endtask

  task automatic test_send_f4();
    logic [10:0] e;
    e = exp_frame(8'hF4);
    do_xfer(8'hF4, 1'b1, 11, 0, 0);
    tests++; if (got_inhibit !== INH) begin failures++; $display("FAIL f4_inhibit_len: got %0d, required %0d", got_inhibit, INH); end
    tests++; if (busy_after_start !== 1'b1) begin failures++; $display("FAIL f4_busy_after_start: got %b, required 1", busy_after_start); end
    tests++; if (busy_dropped !== 1'b0) begin failures++; $display("FAIL f4_busy_gap: got %b, required 0", busy_dropped); end
    tests++; if (got_frame[9] !== e[9]) begin failures++; $display("FAIL f4_parity: got %b, required %b", got_frame[9], e[9]); end
    tests++; if (got_frame !== e) begin failures++; $display("FAIL f4_frame: got %b, required %b", got_frame, e); end
    tests++; if (done_cnt !== 1 || got_ack_err !== 1'b0) begin failures++; $display("FAIL f4_done: got count %0d ack_err %b, required 1 0", done_cnt, got_ack_err); end
  endtask

  task automatic test_nack();
    logic [7:0]  d;
    logic [10:0] e;
    d = 8'($urandom_range(0, 255));
    e = exp_frame(d);
    do_xfer(d, 1'b0, 11, 0, 0);
    tests++; if (got_frame !== e) begin failures++; $display("FAIL nack_frame: got %b, required %b", got_frame, e); end
    tests++; if (done_cnt !== 1) begin failures++; $display("FAIL nack_done_count: got %0d, required 1", done_cnt); end
    tests++; if (got_ack_err !== 1'b1) begin failures++; $display("FAIL nack_ack_err: got %b, required 1", got_ack_err); end
  endtask

  task automatic test_timeout();
    logic [7:0]  d;
    logic [10:0] e;
    d = 8'($urandom_range(0, 255));
    e = exp_frame(d);
    do_xfer(d, 1'b1, 4, 0, 0);
    tests++; if (got_frame[4:0] !== e[4:0]) begin failures++; $display("FAIL tmo_bits: got %b, required %b", got_frame[4:0], e[4:0]); end
    tests++; if (done_cnt !== 1) begin failures++; $display("FAIL tmo_done_count: got %0d, required 1", done_cnt); end
    tests++; if (got_ack_err !== 1'b1) begin failures++; $display("FAIL tmo_ack_err: got %b, required 1", got_ack_err); end
    tests++; if (oe_at_done !== 2'b00) begin failures++; $display("FAIL tmo_oe_released: got %b, required 00", oe_at_done); end
    // Two synchronizer stages and the edge-consuming register add 3 cycles
    tests++; if (done_cyc - last_fall_cyc !== TMO + 3) begin failures++; $display("FAIL tmo_latency: got %0d, required %0d", done_cyc - last_fall_cyc, TMO + 3); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] e;
    e = exp_frame(8'hED);
    do_xfer(8'hED, 1'b1, 11, 1, 0);
    tests++; if (got_frame !== e) begin failures++; $display("FAIL b2b_frame: got %b, required %b", got_frame, e); end
    tests++; if (done_cnt !== 1 || got_ack_err !== 1'b0) begin failures++; $display("FAIL b2b_done: got count %0d ack_err %b, required 1 0", done_cnt, got_ack_err); end
  endtask

  task automatic test_start_on_done();
    do_xfer(8'($urandom_range(0, 255)), 1'b1, 11, 0, 1);
    tests++; if (done_cnt !== 1) begin failures++; $display("FAIL sod_done_count: got %0d, required 1", done_cnt); end
    tests++; if (post_done_busy !== 1'b0) begin failures++; $display("FAIL sod_ignored: got busy %b, required 0", post_done_busy); end
  endtask

  task automatic test_reset_mid();
    logic        s;
    int          w;
    logic [10:0] e;
    e = exp_frame(8'hED);
    done_cnt = 0;
    @(negedge clk);
    tx_data  = 8'hED;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    w = 0;
    while (ps2_clk_oe && w < INH + 50) begin
      w++;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    dev_edge(s);
    dev_edge(s);
    // Bit 1 of 0xED is 0, so the host should be pulling data low here
    tests++; if (ps2_data_oe !== 1'b1) begin failures++; $display("FAIL rm_pre_data_oe: got %b, required 1", ps2_data_oe); end
    reset = 1'b1;
    @(negedge clk);
    tests++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin failures++; $display("FAIL rm_oe_released: got %b%b, required 00", ps2_clk_oe, ps2_data_oe); end
    tests++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy: got %b, required 0", busy); end
    tests++; if (done !== 1'b0) begin failures++; $display("FAIL rm_done: got %b, required 0", done); end
    done_cnt = 0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (30) tick();
    tests++; if (done_cnt !== 0) begin failures++; $display("FAIL rm_no_done: got %0d pulses, required 0", done_cnt); end
    do_xfer(8'hED, 1'b1, 11, 0, 0);
    tests++; if (got_frame !== e) begin failures++; $display("FAIL rm_next_frame: got %b, required %b", got_frame, e); end
    tests++; if (done_cnt !== 1 || got_ack_err !== 1'b0) begin failures++; $display("FAIL rm_next_done: got count %0d ack_err %b, required 1 0", done_cnt, got_ack_err); end
  endtask

  task automatic test_random();
    logic [7:0]  d;
    logic        a;
    logic [10:0] e;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      a = 1'($urandom_range(0, 1));
      e = exp_frame(d);
      do_xfer(d, a, 11, 0, 0);
      tests++; if (got_frame !== e) begin failures++; $display("FAIL rand_frame[%0d]: data %h got %b, required %b", i, d, got_frame, e); end
      tests++; if (done_cnt !== 1 || got_ack_err !== ~a) begin failures++; $display("FAIL rand_done[%0d]: got count %0d ack_err %b, required 1 %b", i, done_cnt, got_ack_err, ~a); end
    end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_send_f4();
    test_nack();
    test_timeout();
    test_back_to_back();
    test_start_on_done();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
